// File: rtl/jfpjc_bitpack_pkg.sv
// Shared definitions for the JPEG entropy-coded bit packer.
//   bp_state_t    : scan control states (RUN accepts codes, DRAIN pads and
//                   flushes the residue, LAST presents the closing word)
//   MARKER_FF     : byte value that must be followed by a stuffed zero byte
//   MARKER_STUFF  : the stuffed zero byte
//   clog2()       : ceiling log2 for elaboration-time width derivation
package jfpjc_bitpack_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    LAST  = 2'd2
  } bp_state_t;

  localparam logic [7:0] MARKER_FF    = 8'hFF;
  localparam logic [7:0] MARKER_STUFF = 8'h00;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bitpack_word_assembler.sv
// Collects bytes into an OUT_BYTES-wide word (first byte in the MSB lane)
// and runs the output valid/ready handshake.
//   clock, nreset : clock and synchronous active-high reset
//   push          : push_byte is written into the next free lane this cycle
//   push_byte     : byte to store
//   present_last  : packer is closing the scan; present whatever is held
//   can_push      : a push is legal this cycle (not full, or full and leaving)
//   out_valid     : word available (full, or closing the scan)
//   out_ready     : downstream accepts the word
//   out_data      : assembled word, unused lanes zero
//   out_nbytes    : filled lanes while out_valid, else 0
//   out_last      : closing (partial or empty) word of the scan
module bitpack_word_assembler
  import jfpjc_bitpack_pkg::*;
#(
  parameter int OUT_BYTES = 4,
  localparam int NB_W = clog2(OUT_BYTES + 1)
) (
  input  logic                   clock,
  input  logic                   nreset,
  input  logic                   push,
  input  logic [7:0]             push_byte,
  input  logic                   present_last,
  output logic                   can_push,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [8*OUT_BYTES-1:0] out_data,
  output logic [NB_W-1:0]        out_nbytes,
  output logic                   out_last
);

  logic [8*OUT_BYTES-1:0] word, word_nxt;
  logic [NB_W-1:0]        fill, fill_nxt;
  logic                   full;
  logic                   take;

  assign full       = (fill == NB_W'(OUT_BYTES));
  assign out_valid  = full || present_last;
  // A full word still pending at scan close goes out as a normal word first;
  // the closing word follows once the lanes are empty.
  assign out_last   = present_last && !full;
  assign out_nbytes = out_valid ? fill : '0;
  assign out_data   = word;
  assign take       = out_valid && out_ready;
  assign can_push   = !full || out_ready;

  always_comb begin
    word_nxt = word;
    fill_nxt = fill;
    if (take) begin
      word_nxt = '0;
      fill_nxt = '0;
      if (push) begin
        word_nxt[8*OUT_BYTES-1 -: 8] = push_byte;
        fill_nxt = NB_W'(1);
      end
    end else if (push) begin
      for (int i = 0; i < OUT_BYTES; i++) begin
        if (fill == NB_W'(i)) word_nxt[8*(OUT_BYTES-1-i) +: 8] = push_byte;
      end
      fill_nxt = fill + NB_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (nreset) begin
      word <= '0;
      fill <= '0;
    end else begin
      word <= word_nxt;
      fill <= fill_nxt;
    end
  end

endmodule

// File: rtl/jpeg_bitpacker.sv
// JPEG entropy-coded segment bit packer. Variable-length codes are packed
// MSB-first, split into bytes with 0xFF -> 0xFF 0x00 stuffing, and grouped
// into OUT_BYTES-wide words. A flush pads the residue with 1s and closes
// the scan with an out_last word holding 0..OUT_BYTES-1 bytes.
//   clock, nreset        : clock and synchronous active-high reset
//   in_valid/in_ready    : code handshake (ready only in RUN with < 8 bits held)
//   in_data, in_length   : code value (low in_length bits used) and length
//   flush                : end of scan, taken together with in_ready
//   out_valid/out_ready  : word handshake
//   out_data             : packed bytes, first byte in the MSB lane
//   out_nbytes           : valid lanes counted from the MSB lane
//   out_last             : final word of the scan
module jpeg_bitpacker
  import jfpjc_bitpack_pkg::*;
#(
  parameter int OUT_BYTES = 4,
  parameter int IN_WIDTH  = 32,
  localparam int LEN_W = clog2(IN_WIDTH + 1),
  localparam int NB_W  = clog2(OUT_BYTES + 1)
) (
  input  logic                   clock,
  input  logic                   nreset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [IN_WIDTH-1:0]    in_data,
  input  logic [LEN_W-1:0]       in_length,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [8*OUT_BYTES-1:0] out_data,
  output logic [NB_W-1:0]        out_nbytes,
  output logic                   out_last
);

  // Codes are only taken while fewer than 8 bits are held, so 7 residual
  // bits plus one maximal code always fit.
  localparam int AW = IN_WIDTH + 7;
  localparam int CW = clog2(IN_WIDTH + 8);

  bp_state_t     state, state_nxt;
  logic [AW-1:0] acc, acc_nxt;
  logic [CW-1:0] count, count_nxt;
  logic          stuff_pending, stuff_nxt;
  logic          accept;
  logic          push;
  logic [7:0]    push_byte;
  logic          can_push;

  function automatic logic [AW-1:0] low_mask(input logic [CW-1:0] n);
    return (AW'(1) << n) - AW'(1);
  endfunction

  // Top 8 of the count valid bits held in acc.
  function automatic logic [7:0] top_byte(input logic [AW-1:0] a,
                                          input logic [CW-1:0] n);
    logic [AW-1:0] sh;
    sh = a >> (n - CW'(8));
    return sh[7:0];
  endfunction

  // Residue of 1..7 bits left-aligned in a byte, low bits filled with 1s.
  function automatic logic [7:0] pad_byte(input logic [AW-1:0] a,
                                          input logic [CW-1:0] n);
    logic [AW-1:0] sh;
    sh = (a << (CW'(8) - n)) | low_mask(CW'(8) - n);
    return sh[7:0];
  endfunction

  assign in_ready = (state == RUN) && (count < CW'(8));
  assign accept   = in_valid && in_ready;

  // acc only ever holds the count valid bits (higher bits kept zero), which
  // keeps the pad computation a plain shift.
  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    count_nxt = count;
    stuff_nxt = stuff_pending;
    push      = 1'b0;
    push_byte = MARKER_STUFF;

    // Accept and byte moves are exclusive: accept needs count < 8.
    if (accept && (in_length != '0)) begin
      acc_nxt   = (acc << in_length) |
                  (AW'(in_data) & low_mask(CW'(in_length)));
      count_nxt = count + CW'(in_length);
    end

    if (can_push && (state != LAST)) begin
      if (stuff_pending) begin
        push      = 1'b1;
        push_byte = MARKER_STUFF;
        stuff_nxt = 1'b0;
      end else if (count >= CW'(8)) begin
        push      = 1'b1;
        push_byte = top_byte(acc, count);
        count_nxt = count - CW'(8);
        acc_nxt   = acc & low_mask(count - CW'(8));
        stuff_nxt = (top_byte(acc, count) == MARKER_FF);
      end else if ((state == DRAIN) && (count != '0)) begin
        push      = 1'b1;
        push_byte = pad_byte(acc, count);
        count_nxt = '0;
        acc_nxt   = '0;
        stuff_nxt = (pad_byte(acc, count) == MARKER_FF);
      end
    end

    case (state)
      RUN:     if (flush && in_ready) state_nxt = DRAIN;
      DRAIN:   if ((count == '0) && !stuff_pending) state_nxt = LAST;
      LAST:    if (out_last && out_ready) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (nreset) begin
      state         <= RUN;
      acc           <= '0;
      count         <= '0;
      stuff_pending <= 1'b0;
    end else begin
      state         <= state_nxt;
      acc           <= acc_nxt;
      count         <= count_nxt;
      stuff_pending <= stuff_nxt;
    end
  end

  bitpack_word_assembler #(
    .OUT_BYTES (OUT_BYTES)
  ) u_word (
    .clock        (clock),
    .nreset       (nreset),
    .push         (push),
    .push_byte    (push_byte),
    .present_last (state == LAST),
    .can_push     (can_push),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_nbytes   (out_nbytes),
    .out_last     (out_last)
  );

  a_len_legal: assume property (@(posedge clock) disable iff (nreset)
    in_valid |-> (in_length <= LEN_W'(IN_WIDTH)));

endmodule

// File: doc/jpeg_bitpacker.md
JPEG_BITPACKER -- requirements
Module: jpeg_bitpacker

Interface
REQ-001 SHALL have parameter OUT_BYTES, default 4, meaning output word width in bytes (1..8).
REQ-002 SHALL have parameter IN_WIDTH, default 32, meaning the maximum input code length in bits (8..32).
REQ-003 SHALL have derived LEN_W = clog2(IN_WIDTH+1) and NB_W = clog2(OUT_BYTES+1).
REQ-004 clock  in  1  clock; all state updates on its rising edge.
REQ-005 nreset  in  1  reset, synchronous, active-high.
REQ-006 in_valid  in  1  input code present.
REQ-007 in_ready  out  1  block accepts the code this cycle.
REQ-008 in_data  in  IN_WIDTH  code; the low in_length bits are significant, and upper bits are ignored.
REQ-009 in_length  in  LEN_W  code length, 0..IN_WIDTH.
REQ-010 flush  in  1  end-of-scan request; honoured only when in_ready=1.
REQ-011 out_valid  out  1  out_data word available.
REQ-012 out_ready  in  1  downstream accepts the word.
REQ-013 out_data  out  8*OUT_BYTES  packed bytes; the first byte is in the most-significant lane.
REQ-014 out_nbytes  out  NB_W  count of valid lanes, counted from the MSB lane.
REQ-015 out_last  out  1  final word of the scan.

Function
REQ-016 SHALL pack bits MSB-first: an accepted code is applied as acc = (acc << in_length) | (in_data & ((1<<in_length)-1)) and count += in_length.
REQ-017 SHALL size the accumulator at IN_WIDTH+7 bits and count at clog2(IN_WIDTH+8) bits.
REQ-018 SHALL drive in_ready = (state==RUN) && (count < 8), combinationally.
REQ-019 SHALL accept a code when in_valid && in_ready; a zero-length code is a no-op.
REQ-020 SHALL move at most one byte per cycle into the output word when count>=8, no stuff is pending, and the word is not full-and-stalled.
  - The byte moved is the top 8 valid bits of acc.
  - count decrements by 8 on the move.
REQ-021 SHALL set a stuff_pending flag after moving byte 0xFF; the next byte slot SHALL be 0x00, which then clears the flag.
REQ-022 SHALL assert out_valid when all OUT_BYTES lanes are filled, and hold out_data, out_nbytes and out_last stable while out_valid && !out_ready.
REQ-023 SHALL allow a byte move in the same cycle as an out_valid && out_ready handshake; that byte goes to lane 0 of a fresh word, and unused lanes are 0.
REQ-024 SHALL use FSM states RUN, DRAIN and LAST.
  - RUN->DRAIN when flush && in_ready.
  - A code accepted in the same cycle as flush is included before the flush.
REQ-025 In DRAIN, SHALL move bytes as in RUN; when count is 1..7 and no stuff is pending, SHALL pad the low bits with 1s to form a byte, which is itself subject to stuffing.
  - DRAIN->LAST when count==0 and stuff_pending==0.
REQ-026 In LAST, SHALL present the partial word with out_valid=1, out_last=1 and out_nbytes = lanes filled (0..OUT_BYTES-1).
  - A zero-byte word is still emitted.
  - LAST->RUN on out_ready.
REQ-027 A full word formed during DRAIN SHALL be emitted with out_last=0.
REQ-028 in_length > IN_WIDTH is illegal; formal SHALL assume it never occurs.

Reset
REQ-029 When nreset=1 at a clock edge, the block SHALL return to these values in the next cycle:
  - acc=0, count=0, stuff_pending=0, state=RUN.
  - out_valid=0, out_data=0, out_nbytes=0, out_last=0.
REQ-030 Reset mid-operation SHALL discard all buffered bits and any stalled word without emitting them.

Structure
REQ-031 Shared package jfpjc_bitpack_pkg SHALL hold the state enum {RUN, DRAIN, LAST}, the JPEG marker constants 8'hFF and 8'h00, and the clog2 function.
REQ-032 SHALL instantiate one sub-module, bitpack_word_assembler, which owns lane fill, out_valid/out_ready handshake and out_nbytes.

Verification
REQ-033 OUT_BYTES=4, codes 0xAB/8, 0xCD/8, 0x12/8, 0x34/8, out_ready=1 -> one word 0xABCD1234, nbytes=4, last=0.
REQ-034 Codes 0xFF/8 and 0x01/8, then flush -> word 0xFF000100, nbytes=3, last=1.
REQ-035 Code 3'b101/3, then flush -> pad byte 0xBF; word 0xBF000000, nbytes=1, last=1.
REQ-036 Code 7'h7F/7, then flush -> pad byte 0xFF is stuffed; word 0xFF000000, nbytes=2, last=1.
REQ-037 Full word with out_ready=0 for 10 cycles -> out_data stable, in_ready=0 once count>=8, no bit lost after release.
  - Also: flush with no data -> word 0x00000000, nbytes=0, last=1.
REQ-038 nreset=1 with count=13 buffered -> outputs zero next cycle; a subsequent 0x11/8 x4 yields 0x11111111.
